// File: rtl/bru_pkg.sv
// Shared types and constants for the branch resolve unit and its per-slot comparator.
package bru_pkg;

    localparam int BRU_PC_W = 11;

    typedef enum logic {
        BRU_IDLE  = 1'b0,
        BRU_FLUSH = 1'b1
    } bru_state_e;

    // Slot1 is the older instruction of the issue pair; its mispredict kills slot2.
    localparam logic BRU_SLOT1_OLDER = 1'b1;

endpackage

// File: rtl/bru_slot_cmp.sv
// Per-slot prediction check: flags a mispredict and forms the corrected fetch PC.
module bru_slot_cmp
    import bru_pkg::*;
#(
    parameter int PC_W = BRU_PC_W
) (
    input  logic            valid,
    input  logic            pred,
    input  logic            taken,
    input  logic [PC_W-1:0] pc,
    input  logic [PC_W-1:0] target,
    output logic            mispredict,
    output logic [PC_W-1:0] corr_pc
);

    always_comb begin
        mispredict = valid && (taken != pred);
        // Fall-through wraps naturally at the top of the PC space.
        corr_pc    = taken ? target : pc + PC_W'(1);
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// Execute-stage branch resolution: BHT update strobes, redirect pulse and flush window.
// Saturating perf counters are built only when BRU_PERF_CNT_EN is defined.
module branch_resolve_unit
    import bru_pkg::*;
#(
    parameter int PC_W         = BRU_PC_W,
    parameter int FLUSH_CYCLES = 2,
    parameter int PERF_W       = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stallE,
    input  logic              branchE1,
    input  logic              branchE2,
    input  logic              predE1,
    input  logic              predE2,
    input  logic              takenE1,
    input  logic              takenE2,
    input  logic [PC_W-1:0]   pcE1,
    input  logic [PC_W-1:0]   pcE2,
    input  logic [PC_W-1:0]   targetE1,
    input  logic [PC_W-1:0]   targetE2,
    output logic              upd_branch1,
    output logic              upd_branch2,
    output logic              upd_taken1,
    output logic              upd_taken2,
    output logic [PC_W-1:0]   upd_pc1,
    output logic [PC_W-1:0]   upd_pc2,
    output logic              redirect_valid,
    output logic [PC_W-1:0]   redirect_pc,
    output logic              flush,
    output logic [PERF_W-1:0] br_count,
    output logic [PERF_W-1:0] mispred_count
);

    localparam int               CNT_W      = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [CNT_W-1:0] FLUSH_INIT = CNT_W'(FLUSH_CYCLES - 1);

    bru_state_e       state_q, state_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic             flush_q, flush_d;
    logic             redirect_valid_q, redirect_valid_d;
    logic [PC_W-1:0]  redirect_pc_q, redirect_pc_d;
    logic             upd_branch1_q, upd_branch1_d;
    logic             upd_branch2_q, upd_branch2_d;
    logic             upd_taken1_q, upd_taken1_d;
    logic             upd_taken2_q, upd_taken2_d;
    logic [PC_W-1:0]  upd_pc1_q, upd_pc1_d;
    logic [PC_W-1:0]  upd_pc2_q, upd_pc2_d;

    logic             resolve;
    logic             v1, v2;
    logic             mis1, mis2;
    logic [PC_W-1:0]  corr_pc1, corr_pc2;

    assign resolve = (state_q == BRU_IDLE) && !stallE;
    assign v1      = resolve && branchE1;
    assign v2      = resolve && branchE2 && !(mis1 && BRU_SLOT1_OLDER);

    bru_slot_cmp #(.PC_W(PC_W)) u_slot1 (
        .valid      (v1),
        .pred       (predE1),
        .taken      (takenE1),
        .pc         (pcE1),
        .target     (targetE1),
        .mispredict (mis1),
        .corr_pc    (corr_pc1)
    );

    bru_slot_cmp #(.PC_W(PC_W)) u_slot2 (
        .valid      (v2),
        .pred       (predE2),
        .taken      (takenE2),
        .pc         (pcE2),
        .target     (targetE2),
        .mispredict (mis2),
        .corr_pc    (corr_pc2)
    );

    // NOTE: every signal gets a default at the top of the block so no path leaves it unassigned (no latch).
    always_comb begin
        state_d          = state_q;
        flush_cnt_d      = flush_cnt_q;
        flush_d          = 1'b0;
        redirect_valid_d = 1'b0;
        redirect_pc_d    = '0;

        case (state_q)
            BRU_IDLE: begin
                if (mis1 || mis2) begin
                    state_d          = BRU_FLUSH;
                    flush_cnt_d      = FLUSH_INIT;
                    flush_d          = 1'b1;
                    redirect_valid_d = 1'b1;
                    redirect_pc_d    = mis1 ? corr_pc1 : corr_pc2;
                end
            end
            BRU_FLUSH: begin
                if (flush_cnt_q == '0) begin
                    state_d = BRU_IDLE;
                end else begin
                    flush_cnt_d = flush_cnt_q - CNT_W'(1);
                    flush_d     = 1'b1;
                end
            end
            default: state_d = BRU_IDLE;
        endcase

        upd_branch1_d = v1;
        upd_branch2_d = v2;
        upd_taken1_d  = resolve && takenE1;
        upd_taken2_d  = resolve && takenE2;
        upd_pc1_d     = resolve ? pcE1 : '0;
        upd_pc2_d     = resolve ? pcE2 : '0;
    end

    // NOTE: sequential state uses non-blocking assignments; reset is sampled on the clock edge.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q          <= BRU_IDLE;
            flush_cnt_q      <= '0;
            flush_q          <= 1'b0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
            upd_branch1_q    <= 1'b0;
            upd_branch2_q    <= 1'b0;
            upd_taken1_q     <= 1'b0;
            upd_taken2_q     <= 1'b0;
            upd_pc1_q        <= '0;
            upd_pc2_q        <= '0;
        end else begin
            state_q          <= state_d;
            flush_cnt_q      <= flush_cnt_d;
            flush_q          <= flush_d;
            redirect_valid_q <= redirect_valid_d;
            redirect_pc_q    <= redirect_pc_d;
            upd_branch1_q    <= upd_branch1_d;
            upd_branch2_q    <= upd_branch2_d;
            upd_taken1_q     <= upd_taken1_d;
            upd_taken2_q     <= upd_taken2_d;
            upd_pc1_q        <= upd_pc1_d;
            upd_pc2_q        <= upd_pc2_d;
        end
    end

    assign upd_branch1    = upd_branch1_q;
    assign upd_branch2    = upd_branch2_q;
    assign upd_taken1     = upd_taken1_q;
    assign upd_taken2     = upd_taken2_q;
    assign upd_pc1        = upd_pc1_q;
    assign upd_pc2        = upd_pc2_q;
    assign redirect_valid = redirect_valid_q;
    assign redirect_pc    = redirect_pc_q;
    assign flush          = flush_q;

`ifdef BRU_PERF_CNT_EN
    logic [PERF_W-1:0] br_count_q, br_count_d;
    logic [PERF_W-1:0] mispred_count_q, mispred_count_d;
    logic [PERF_W:0]   br_sum;

    // The extra sum bit detects overflow so the counter pins at all-ones.
    always_comb begin
        br_sum          = {1'b0, br_count_q} + (PERF_W+1)'({1'b0, v1} + {1'b0, v2});
        br_count_d      = br_sum[PERF_W] ? '1 : br_sum[PERF_W-1:0];
        mispred_count_d = mispred_count_q;
        if ((mis1 || mis2) && (mispred_count_q != '1)) begin
            mispred_count_d = mispred_count_q + PERF_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            br_count_q      <= '0;
            mispred_count_q <= '0;
        end else begin
            br_count_q      <= br_count_d;
            mispred_count_q <= mispred_count_d;
        end
    end

    assign br_count      = br_count_q;
    assign mispred_count = mispred_count_q;
`else
    assign br_count      = '0;
    assign mispred_count = '0;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Scoreboard bench for branch_resolve_unit: directed scenarios then random traffic vs a behavioural model.
module tb_branch_resolve_unit;

    localparam int PC_W    = 11;
    localparam int FLUSH_N = 2;
    localparam int PERF_W  = 6;
    localparam int PMAX    = (1 << PERF_W) - 1;

    logic              clk;
    logic              reset;
    logic              stallE;
    logic              branchE1, branchE2, predE1, predE2, takenE1, takenE2;
    logic [PC_W-1:0]   pcE1, pcE2, targetE1, targetE2;
    logic              upd_branch1, upd_branch2, upd_taken1, upd_taken2;
    logic [PC_W-1:0]   upd_pc1, upd_pc2;
    logic              redirect_valid;
    logic [PC_W-1:0]   redirect_pc;
    logic              flush;
    logic [PERF_W-1:0] br_count, mispred_count;

    branch_resolve_unit #(
        .PC_W         (PC_W),
        .FLUSH_CYCLES (FLUSH_N),
        .PERF_W       (PERF_W)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .stallE         (stallE),
        .branchE1       (branchE1),
        .branchE2       (branchE2),
        .predE1         (predE1),
        .predE2         (predE2),
        .takenE1        (takenE1),
        .takenE2        (takenE2),
        .pcE1           (pcE1),
        .pcE2           (pcE2),
        .targetE1       (targetE1),
        .targetE2       (targetE2),
        .upd_branch1    (upd_branch1),
        .upd_branch2    (upd_branch2),
        .upd_taken1     (upd_taken1),
        .upd_taken2     (upd_taken2),
        .upd_pc1        (upd_pc1),
        .upd_pc2        (upd_pc2),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .flush          (flush),
        .br_count       (br_count),
        .mispred_count  (mispred_count)
    );

    typedef struct {
        logic            rst_n, stall;
        logic            b1, p1, t1, b2, p2, t2;
        logic [PC_W-1:0] pc1, tg1, pc2, tg2;
    } stim_t;

    typedef struct {
        int              tag;
        logic            b1, b2, t1, t2;
        logic [PC_W-1:0] pc1, pc2;
    } upd_exp_t;

    typedef struct {
        int              tag;
        logic [PC_W-1:0] pc;
    } rd_exp_t;

    typedef struct {
        int tag;
        logic fl;
        int bc, mc;
    } cyc_exp_t;

    upd_exp_t upd_q[$];
    rd_exp_t  rd_q[$];
    cyc_exp_t cyc_q[$];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Model state: cycles of input blindness left, and the two event tallies.
    int flush_left = 0;
    int m_br       = 0;
    int m_mis      = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle=%0d actual=0x%0h expected=0x%0h", name, cyc, act, exp);
        end
    endtask

    function automatic stim_t mk(input logic b1, input logic p1, input logic t1,
                                 input logic [PC_W-1:0] pc1, input logic [PC_W-1:0] tg1,
                                 input logic b2, input logic p2, input logic t2,
                                 input logic [PC_W-1:0] pc2, input logic [PC_W-1:0] tg2,
                                 input logic stall = 1'b0, input logic rst_n = 1'b1);
        stim_t s;
        s.rst_n = rst_n; s.stall = stall;
        s.b1 = b1; s.p1 = p1; s.t1 = t1; s.pc1 = pc1; s.tg1 = tg1;
        s.b2 = b2; s.p2 = p2; s.t2 = t2; s.pc2 = pc2; s.tg2 = tg2;
        return s;
    endfunction

    function automatic stim_t idle_stim(input logic rst_n = 1'b1);
        return mk(0, 0, 0, '0, '0, 0, 0, 0, '0, '0, 1'b0, rst_n);
    endfunction

    function automatic logic [PC_W-1:0] fix_pc(input logic taken, input logic [PC_W-1:0] pc,
                                               input logic [PC_W-1:0] tg);
        int nxt;
        nxt = (int'(pc) + 1) % (1 << PC_W);
        return taken ? tg : PC_W'(nxt);
    endfunction

    // Apply one cycle of inputs, predict what the DUT shows after the coming edge, then clock.
    task automatic drive(input stim_t s);
        upd_exp_t ue;
        rd_exp_t  re;
        cyc_exp_t ce;
        logic     v1, v2, m1, m2;
        int       tag;
        tag = cyc + 1;
        reset = s.rst_n; stallE = s.stall;
        branchE1 = s.b1; predE1 = s.p1; takenE1 = s.t1; pcE1 = s.pc1; targetE1 = s.tg1;
        branchE2 = s.b2; predE2 = s.p2; takenE2 = s.t2; pcE2 = s.pc2; targetE2 = s.tg2;

        if (!s.rst_n) begin
            flush_left = 0; m_br = 0; m_mis = 0;
        end else if (flush_left > 0) begin
            flush_left--;
        end else if (!s.stall) begin
            v1 = s.b1;
            m1 = v1 && (s.t1 != s.p1);
            v2 = s.b2 && !m1;
            m2 = v2 && (s.t2 != s.p2);
            if (v1 || v2) begin
                ue.tag = tag; ue.b1 = v1; ue.b2 = v2; ue.t1 = s.t1; ue.t2 = s.t2;
                ue.pc1 = s.pc1; ue.pc2 = s.pc2;
                upd_q.push_back(ue);
            end
            if (m1 || m2) begin
                re.tag = tag;
                re.pc  = m1 ? fix_pc(s.t1, s.pc1, s.tg1) : fix_pc(s.t2, s.pc2, s.tg2);
                rd_q.push_back(re);
                flush_left = FLUSH_N;
            end
`ifdef BRU_PERF_CNT_EN
            m_br = m_br + int'(v1) + int'(v2);
            if (m_br > PMAX) m_br = PMAX;
            if ((m1 || m2) && m_mis < PMAX) m_mis++;
`endif
        end
        ce.tag = tag; ce.fl = (flush_left > 0); ce.bc = m_br; ce.mc = m_mis;
        cyc_q.push_back(ce);
        @(posedge clk);
        #1;
    endtask

    // Monitor: compares on the falling edge, popping expectations only when the DUT presents them.
    upd_exp_t mu;
    rd_exp_t  mr;
    cyc_exp_t mc;
    always @(negedge clk) begin
        if (cyc_q.size() > 0 && cyc_q[0].tag <= cyc) begin
            mc = cyc_q.pop_front();
            check("cycle_tag", cyc, mc.tag);
            check("flush", flush, mc.fl);
            check("br_count", br_count, mc.bc);
            check("mispred_count", mispred_count, mc.mc);
        end
        while (upd_q.size() > 0 && upd_q[0].tag < cyc) begin
            mu = upd_q.pop_front();
            check("upd_missing_at", cyc, mu.tag);
        end
        while (rd_q.size() > 0 && rd_q[0].tag < cyc) begin
            mr = rd_q.pop_front();
            check("redirect_missing_at", cyc, mr.tag);
        end
        if (upd_branch1 === 1'b1 || upd_branch2 === 1'b1) begin
            if (upd_q.size() == 0) begin
                check("upd_spurious", {upd_branch1, upd_branch2}, 0);
            end else begin
                mu = upd_q.pop_front();
                check("upd_cycle", cyc, mu.tag);
                check("upd_branch1", upd_branch1, mu.b1);
                check("upd_branch2", upd_branch2, mu.b2);
                if (mu.b1) begin
                    check("upd_taken1", upd_taken1, mu.t1);
                    check("upd_pc1", upd_pc1, mu.pc1);
                end
                if (mu.b2) begin
                    check("upd_taken2", upd_taken2, mu.t2);
                    check("upd_pc2", upd_pc2, mu.pc2);
                end
            end
        end
        if (redirect_valid === 1'b1) begin
            if (rd_q.size() == 0) begin
                check("redirect_spurious", redirect_valid, 0);
            end else begin
                mr = rd_q.pop_front();
                check("redirect_cycle", cyc, mr.tag);
                check("redirect_pc", redirect_pc, mr.pc);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog cycle=%0d actual=timeout required=finish", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        stim_t s;
        drive(idle_stim(1'b0));
        drive(idle_stim(1'b0));
        check("reset_upd_branch1", upd_branch1, 0);
        check("reset_redirect_valid", redirect_valid, 0);
        check("reset_upd_pc1", upd_pc1, 0);

        // Correct not-taken slot1 branch, no slot2.
        drive(mk(1, 0, 0, 11'h010, 11'h055, 0, 0, 0, '0, '0));
        drive(idle_stim());

        // Slot1 mispredicts taken; slot2 dropped; branches in the flush window are ignored.
        drive(mk(1, 0, 1, 11'h020, 11'h120, 1, 0, 0, 11'h021, 11'h300));
        drive(mk(1, 1, 1, 11'h130, 11'h200, 1, 0, 0, 11'h131, 11'h000));
        drive(mk(1, 0, 1, 11'h131, 11'h222, 0, 0, 0, '0, '0));
        drive(idle_stim());

        // Slot1 correct, slot2 mispredicts not-taken at the top of the PC space.
        drive(mk(1, 1, 1, 11'h7FE, 11'h7FF, 1, 1, 0, 11'h7FF, 11'h400));
        drive(idle_stim());
        drive(idle_stim());

        // Stalled mispredict held three cycles, then released.
        s = mk(1, 1, 0, 11'h0A0, 11'h3C0, 0, 0, 0, '0, '0, 1'b1);
        repeat (3) drive(s);
        s.stall = 1'b0;
        drive(s);
        drive(idle_stim());
        drive(idle_stim());

        // Back-to-back: mispredict on the first IDLE cycle after a window.
        drive(mk(0, 0, 0, '0, '0, 1, 0, 1, 11'h050, 11'h600));
        drive(idle_stim());
        drive(idle_stim());
        drive(mk(1, 1, 0, 11'h600, 11'h100, 0, 0, 0, '0, '0));
        drive(idle_stim());
        drive(idle_stim());

        // Reset on the first flush cycle aborts the window; next branch resolves normally.
        drive(mk(1, 0, 1, 11'h040, 11'h444, 0, 0, 0, '0, '0));
        drive(idle_stim(1'b0));
        drive(mk(1, 0, 0, 11'h044, 11'h000, 1, 1, 1, 11'h045, 11'h080));
        drive(idle_stim());

        // Counter run from a clean reset: 5x two correct branches, then one mispredict.
        drive(idle_stim(1'b0));
        for (int i = 0; i < 5; i++) begin
            drive(mk(1, 1, 1, PC_W'(i), 11'h111, 1, 0, 0, PC_W'(i + 1), 11'h222));
        end
        drive(mk(1, 0, 1, 11'h070, 11'h170, 0, 0, 0, '0, '0));
        drive(idle_stim());
        drive(idle_stim());

        // Random traffic; long enough to push the narrow counters into saturation.
        for (int i = 0; i < 3000; i++) begin
            s.rst_n = ($urandom_range(199) != 0);
            s.stall = ($urandom_range(3) == 0);
            s.b1 = $urandom_range(1); s.p1 = $urandom_range(1); s.t1 = $urandom_range(1);
            s.b2 = $urandom_range(1); s.p2 = $urandom_range(1); s.t2 = $urandom_range(1);
            s.pc1 = PC_W'($urandom); s.tg1 = PC_W'($urandom);
            s.pc2 = PC_W'($urandom); s.tg2 = PC_W'($urandom);
            if ($urandom_range(7) == 0) s.pc2 = '1;
            drive(s);
        end

        repeat (4) drive(idle_stim());
        @(negedge clk);
        check("upd_queue_drained", upd_q.size(), 0);
        check("redirect_queue_drained", rd_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
